// File: rtl/mem_inst_dp.sv
// -----------------------------------------------------------------------------
// mem_inst_dp
//
// Instruction/data memory with one write port and two independent read ports.
// A bulk program loader shares the write port with the direct write path.
// While the loader is in LOAD it owns the port. Any direct write made then is
// discarded, and wr_drop pulses in the next cycle.
//
// Read collision behaviour (the read and the committing write target the same
// word in the same cycle):
//   RD_MODE = 0 : write-first. The read returns the old word with the written
//                 bytes merged in.
//   RD_MODE = 1 : read-first. The read returns the old word.
// OUT_REG = 1 adds one register stage to both read ports, so read latency
// becomes 2 cycles.
//
// Ports
//   clk, reset                     single clock; reset is synchronous, active-high
//   we, waddr, wdata, wbe          direct write with per-byte enables
//   r1en, r1addr -> r1data, r1valid   read port 1
//   r2en, r2addr -> r2data, r2valid   read port 2
//   prog_start, prog_base          start a bulk load at word address prog_base
//   prog_wvalid, prog_wdata,       load stream; prog_last marks the final word
//   prog_last -> prog_wready
//   prog_done, prog_busy, wr_drop  loader status and dropped-write pulse
// -----------------------------------------------------------------------------
module mem_inst_dp #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  // direct write port
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  // read port 1
  input  logic                    r1en,
  input  logic [ADDR_WIDTH-1:0]   r1addr,
  output logic [DATA_WIDTH-1:0]   r1data,
  output logic                    r1valid,
  // read port 2
  input  logic                    r2en,
  input  logic [ADDR_WIDTH-1:0]   r2addr,
  output logic [DATA_WIDTH-1:0]   r2data,
  output logic                    r2valid,
  // program loader
  input  logic                    prog_start,
  input  logic [ADDR_WIDTH-1:0]   prog_base,
  input  logic                    prog_wvalid,
  input  logic [DATA_WIDTH-1:0]   prog_wdata,
  input  logic                    prog_last,
  output logic                    prog_wready,
  output logic                    prog_done,
  output logic                    prog_busy,
  output logic                    wr_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;

  // NOTE: every signal written in a combinational block gets a default at the
  // top. A path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    prog_wready = 1'b0;
    prog_busy   = 1'b0;
    prog_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (prog_start) begin
          w_ptr_nxt   = prog_base;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        prog_wready = 1'b1;
        prog_busy   = 1'b1;
        // prog_last only counts when it comes with a valid word.
        if (prog_wvalid) begin
          // The pointer is exactly ADDR_WIDTH bits wide, so the top word wraps to 0.
          w_ptr_nxt = r_ptr + 1'b1;
          if (prog_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        prog_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, so no block sees another's new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-port arbitration: the loader owns the port for the whole LOAD state.
  // ---------------------------------------------------------------------------
  logic                  w_wr_en;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [NB-1:0]         w_wr_be;
  logic                  w_drop;
  logic                  r_wr_drop;

  always_comb begin
    w_wr_en   = we;
    w_wr_addr = waddr;
    w_wr_data = wdata;
    w_wr_be   = wbe;
    w_drop    = 1'b0;
    if (r_state == S_LOAD) begin
      w_wr_en   = prog_wvalid;
      w_wr_addr = r_ptr;
      w_wr_data = prog_wdata;
      w_wr_be   = '1;
      w_drop    = we;
    end
  end

  // No write commits in a cycle where reset is asserted.
  assign w_commit = w_wr_en & ~reset;

  always_ff @(posedge clk) begin
    if (reset) r_wr_drop <= 1'b0;
    else       r_wr_drop <= w_drop;
  end

  assign wr_drop = r_wr_drop;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset. Clearing it would force it out of RAM
  // macros into flops, and its contents are undefined after reset anyway.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wr_be[b]) r_mem[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports (index 0 = port 1, index 1 = port 2)
  // ---------------------------------------------------------------------------
  logic [1:0]            w_ren;
  logic [ADDR_WIDTH-1:0] w_raddr [2];
  logic [DATA_WIDTH-1:0] w_rword [2];
  logic [DATA_WIDTH-1:0] r_rdata [2];
  logic [1:0]            r_rvalid;

  assign w_ren      = {r2en, r1en};
  assign w_raddr[0] = r1addr;
  assign w_raddr[1] = r2addr;

  // In write-first mode, bytes being written this cycle bypass into the read word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rword[p] = r_mem[w_raddr[p]];
      if ((RD_MODE == 0) && w_commit && (w_wr_addr == w_raddr[p])) begin
        for (int b = 0; b < NB; b++) begin
          if (w_wr_be[b]) w_rword[p][8*b +: 8] = w_wr_data[8*b +: 8];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_s1_data [2];
    logic [1:0]            r_s1_valid;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1_valid <= '0;
        r_rvalid   <= '0;
        for (int p = 0; p < 2; p++) begin
          r_s1_data[p] <= '0;
          r_rdata[p]   <= '0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          r_s1_valid[p] <= w_ren[p];
          if (w_ren[p]) r_s1_data[p] <= w_rword[p];
          r_rvalid[p] <= r_s1_valid[p];
          if (r_s1_valid[p]) r_rdata[p] <= r_s1_data[p];
        end
      end
    end
  end else begin : g_no_out_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        r_rvalid <= '0;
        for (int p = 0; p < 2; p++) r_rdata[p] <= '0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          r_rvalid[p] <= w_ren[p];
          if (w_ren[p]) r_rdata[p] <= w_rword[p];
        end
      end
    end
  end

  assign r1data  = r_rdata[0];
  assign r1valid = r_rvalid[0];
  assign r2data  = r_rdata[1];
  assign r2valid = r_rvalid[1];

endmodule

// File: doc/mem_inst_dp.md
MEM_INST_DP -- requirements
Module: mem_inst_dp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, word-address width; depth is 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; must be a multiple of 8.
REQ-003 SHALL have parameter RD_MODE, default 0; 0 = write-first, 1 = read-first on a same-address collision.
REQ-004 SHALL have parameter OUT_REG, default 0; 1 = extra output register stage on both read ports.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-007 SHALL have ports we (in, 1), waddr (in, ADDR_WIDTH), wdata (in, DATA_WIDTH), wbe (in, DATA_WIDTH/8); direct write port with byte enables.
REQ-008 SHALL have ports r1en (in, 1), r1addr (in, ADDR_WIDTH), r1data (out, DATA_WIDTH), r1valid (out, 1); read port 1.
REQ-009 SHALL have ports r2en, r2addr, r2data and r2valid, with the same widths and directions as the port-1 signals; read port 2.
REQ-010 SHALL have ports prog_start (in, 1) and prog_base (in, ADDR_WIDTH); start a bulk program load at base address prog_base.
REQ-011 SHALL have ports prog_wvalid (in, 1), prog_wdata (in, DATA_WIDTH), prog_last (in, 1) and prog_wready (out, 1); the load stream.
REQ-012 SHALL have ports prog_done (out, 1), prog_busy (out, 1) and wr_drop (out, 1); status outputs.

Function
REQ-013 SHALL store 2^ADDR_WIDTH words; contents are not initialised by reset.
REQ-014 Direct write SHALL occur on a clk edge with we=1, writing byte i of wdata to byte i of mem[waddr] only where wbe[i]=1.
REQ-015 A read with rNen=1 SHALL present mem[rNaddr] on rNdata, with rNvalid=1, 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
REQ-016 With rNen=0, rNvalid SHALL be 0 in the corresponding cycle and rNdata SHALL hold its previous value.
REQ-017 On a same-address read/write collision, RD_MODE=0 SHALL return the old word merged with the written bytes; RD_MODE=1 SHALL return the old word.
REQ-018 Both read ports SHALL operate independently, including when both address the same word.
REQ-019 The loader FSM SHALL have exactly the states IDLE, LOAD and DONE.
REQ-020 IDLE: on prog_start=1, the load pointer SHALL take prog_base and the FSM SHALL go to LOAD; prog_start is ignored in LOAD and DONE.
REQ-021 LOAD: prog_wready=1 and prog_busy=1.
REQ-022 LOAD: each cycle with prog_wvalid=1 SHALL write the full word prog_wdata (all bytes enabled) at the pointer, then increment the pointer.
REQ-023 The pointer SHALL wrap from 2^ADDR_WIDTH-1 to 0.
REQ-024 LOAD: prog_wvalid=1 with prog_last=1 SHALL write that word and go to DONE.
REQ-025 LOAD: prog_last=1 with prog_wvalid=0 SHALL be ignored.
REQ-026 DONE SHALL last exactly 1 cycle with prog_done=1 and prog_wready=0, then the FSM SHALL go to IDLE.
REQ-027 Outside LOAD, prog_wready=0 and prog_busy=0.
REQ-028 While prog_busy=1, any direct write (we=1) SHALL be discarded and wr_drop SHALL pulse 1 in the following cycle; reads remain serviced.
REQ-029 Loader writes SHALL obey the RD_MODE collision rule against both read ports.
REQ-030 The write path SHALL be a single port; at most one write (loader or direct) commits per cycle.

Reset
REQ-031 reset=1 at a clk edge SHALL force FSM=IDLE, pointer=0, r1data=r2data=0, r1valid=r2valid=0, prog_done=0, prog_wready=0, prog_busy=0, wr_drop=0, and clear the OUT_REG pipeline stage.
REQ-032 Reset mid-LOAD SHALL abort the load and keep words already written; a write presented in the reset cycle SHALL NOT commit.
REQ-033 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-034 Byte-enable write: write 0x00000000 to addr 5, then we=1, waddr=5, wdata=0xAABBCCDD, wbe=4'b0101, then read r1addr=5 -> r1data=0x00BB00DD, r1valid 1 cycle after r1en (OUT_REG=0).
REQ-035 Collision: mem[7]=0x11111111; same cycle write 0x22222222 with wbe=4'hF and r2addr=7 -> r2data=0x22222222 (RD_MODE=0) or 0x11111111 (RD_MODE=1).
REQ-036 Wrapping load: prog_start with prog_base=510 (ADDR_WIDTH=9), 4 words 0xA0..0xA3, last with prog_last -> words land at 510, 511, 0, 1; prog_done=1 for exactly 1 cycle, then prog_busy=0.
REQ-037 Dropped write: during LOAD, we=1, waddr=3 -> mem[3] unchanged; wr_drop=1 for 1 cycle.
REQ-038 Reset mid-load: reset after the 2nd of 4 load words -> first 2 words present; FSM IDLE; all outputs 0; prog_done never asserted.
REQ-039 Output register: with OUT_REG=1, r1en pulsed at cycle n -> r1valid=1 at cycle n+2 only, r1data correct.
